// File: rtl/elastic_pipeline_if.sv
// Handshake bundle for elastic_pipeline: upstream valid/ready/data, downstream
// valid/ready/data and the occupancy count. The pipeline uses the slave modport.
interface elastic_pipeline_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] occupancy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/elastic_pipeline.sv
// Flow-controlled DEPTH-stage register pipeline with bubble collapse and an
// occupancy count. Defining PIPE_FLUSH_EN adds a flush input that empties all stages.
module elastic_pipeline #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef PIPE_FLUSH_EN
    input  logic flush,
`endif
    elastic_pipeline_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_depthCheck
        $error("elastic_pipeline: DEPTH must be at least 1");
    end

    logic [DEPTH:1]   stageValid_q;
    logic [DEPTH:1]   stageValid_d;
    logic [WIDTH-1:0] stageData_q [1:DEPTH];
    logic [WIDTH-1:0] stageData_d [1:DEPTH];
    logic [DEPTH:1]   stageReady;
    logic [DEPTH:1]   upValid;
    logic [WIDTH-1:0] upData [1:DEPTH];
    logic [CNT_W-1:0] occupancy_q;
    logic [CNT_W-1:0] occupancy_d;
    logic             flushActive;
    logic             inXfer;
    logic             outXfer;

`ifdef PIPE_FLUSH_EN
    assign flushActive = flush;
`else
    assign flushActive = 1'b0;
`endif

    // A stage can accept when it is empty or the stage ahead of it can accept.
    always_comb begin
        logic chain;
        chain = !stageValid_q[DEPTH] || bus.out_ready;
        stageReady = '0;
        stageReady[DEPTH] = chain;
        for (int n = DEPTH - 1; n >= 1; n--) begin
            chain = !stageValid_q[n] || chain;
            stageReady[n] = chain;
        end
    end

    always_comb begin
        upValid[1] = bus.in_valid;
        upData[1]  = bus.in_data;
        for (int n = 2; n <= DEPTH; n++) begin
            upValid[n] = stageValid_q[n-1];
            upData[n]  = stageData_q[n-1];
        end
    end

    // Payload only moves with a valid word, so an empty stage keeps its last data.
    always_comb begin
        stageValid_d = stageValid_q;
        stageData_d  = stageData_q;
        for (int n = 1; n <= DEPTH; n++) begin
            if (stageReady[n]) begin
                stageValid_d[n] = upValid[n];
                if (upValid[n]) begin
                    stageData_d[n] = upData[n];
                end
            end
        end
    end

    assign inXfer      = bus.in_valid && bus.in_ready;
    assign outXfer     = stageValid_q[DEPTH] && bus.out_ready;
    assign occupancy_d = occupancy_q + CNT_W'(inXfer) - CNT_W'(outXfer);

    always_ff @(posedge clk) begin
        if (rst) begin
            stageValid_q <= '0;
            occupancy_q  <= '0;
            for (int n = 1; n <= DEPTH; n++) begin
                stageData_q[n] <= '0;
            end
        end else if (flushActive) begin
            stageValid_q <= '0;
            occupancy_q  <= '0;
        end else begin
            stageValid_q <= stageValid_d;
            stageData_q  <= stageData_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign bus.in_ready  = stageReady[1] && !flushActive;
    assign bus.out_valid = stageValid_q[DEPTH];
    assign bus.out_data  = stageData_q[DEPTH];
    assign bus.occupancy = occupancy_q;
endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: DEPTH=3 and DEPTH=4 instances share one stimulus
// stream and are each checked every cycle against a queue-of-words model.
module tb_elastic_pipeline;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid;
    logic [W-1:0] inData;
    logic         outReady;
    logic         flushDrv;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Each word carries the stage it sits in; a word advances one stage per edge
    // unless the next-older word stays directly ahead of it.
    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int D = 3 + g;

        elastic_pipeline_if #(.WIDTH(W), .DEPTH(D)) bus ();

        assign bus.in_valid  = inValid;
        assign bus.in_data   = inData;
        assign bus.out_ready = outReady;

        elastic_pipeline #(.WIDTH(W), .DEPTH(D)) dut (
            .clk   (clk),
            .rst   (rst),
`ifdef PIPE_FLUSH_EN
            .flush (flushDrv),
`endif
            .bus   (bus.slave)
        );

        logic [W-1:0] qData[$];
        int           qPos[$];
        logic [W-1:0] lastOut = '0;
        bit           armed = 1'b0;
        bit           holdPrev = 1'b0;
        logic [W-1:0] holdData = '0;

        always @(posedge clk) begin
            bit outX;
            bit inX;
            int lim;
            if (rst) begin
                qData.delete();
                qPos.delete();
                lastOut = '0;
                armed = 1'b1;
            end else if (flushDrv) begin
                qData.delete();
                qPos.delete();
            end else begin
                outX = qPos.size() > 0 && qPos[0] == D && outReady;
                inX  = inValid && (qPos.size() < D || outReady);
                if (outX) begin
                    void'(qData.pop_front());
                    void'(qPos.pop_front());
                end
                lim = D + 1;
                foreach (qPos[k]) begin
                    qPos[k] = (qPos[k] + 1 < lim - 1) ? qPos[k] + 1 : lim - 1;
                    lim = qPos[k];
                    if (qPos[k] == D) lastOut = qData[k];
                end
                if (inX) begin
                    qData.push_back(inData);
                    qPos.push_back(1);
                end
            end
        end

        always @(negedge clk) begin
            bit           expValid;
            logic [W-1:0] expData;
            if (armed) begin
                expValid = qPos.size() > 0 && qPos[0] == D;
                expData  = expValid ? qData[0] : lastOut;
                checkOutput($sformatf("d%0d out_valid", D), 64'(bus.out_valid), 64'(expValid));
                checkOutput($sformatf("d%0d out_data", D), 64'(bus.out_data), 64'(expData));
                checkOutput($sformatf("d%0d occupancy", D), 64'(bus.occupancy), 64'(qPos.size()));
                checkOutput($sformatf("d%0d in_ready", D), 64'(bus.in_ready),
                            64'((qPos.size() < D || outReady) && !flushDrv));
                if (holdPrev) begin
                    checkOutput($sformatf("d%0d stall valid", D), 64'(bus.out_valid), 64'(1));
                    checkOutput($sformatf("d%0d stall data", D), 64'(bus.out_data), 64'(holdData));
                end
                holdPrev = bus.out_valid && !outReady && !rst && !flushDrv;
                holdData = bus.out_data;
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic ordy,
                                 input logic r, input logic f);
        rst      = r;
        inValid  = v;
        inData   = d;
        outReady = ordy;
        flushDrv = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a live input word that must be ignored.
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        rst = 1'b0; inValid = 1'b0; outReady = 1'b0;
        #1;
        checkOutput("reset out_valid", 64'(g_inst[0].bus.out_valid), 64'(0));
        checkOutput("reset out_data", 64'(g_inst[0].bus.out_data), 64'(0));
        checkOutput("reset occupancy", 64'(g_inst[0].bus.occupancy), 64'(0));
        checkOutput("reset in_ready", 64'(g_inst[0].bus.in_ready), 64'(1));

        // Back-to-back streaming: word i is visible on DEPTH=3 after the push of word i+2.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
            if (i >= 3) begin
                checkOutput("stream d3 data", 64'(g_inst[0].bus.out_data), 64'(i - 2));
                checkOutput("stream d3 valid", 64'(g_inst[0].bus.out_valid), 64'(1));
                checkOutput("stream d3 occupancy", 64'(g_inst[0].bus.occupancy), 64'(3));
            end
        end
        checkOutput("stream d4 data", 64'(g_inst[1].bus.out_data), 64'(13));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain d3 last", 64'(g_inst[0].bus.out_data), 64'(16));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain d3 valid", 64'(g_inst[0].bus.out_valid), 64'(0));
        checkOutput("drain d3 data held", 64'(g_inst[0].bus.out_data), 64'(16));
        checkOutput("drain d4 occupancy", 64'(g_inst[1].bus.occupancy), 64'(0));

        // Fill DEPTH=4 under stall with A0..A3, then hold A4 at the input.
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, W'(32'hA0 + j), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("fill d4 occupancy", 64'(g_inst[1].bus.occupancy), 64'(4));
        checkOutput("fill d4 valid", 64'(g_inst[1].bus.out_valid), 64'(1));
        checkOutput("fill d4 data", 64'(g_inst[1].bus.out_data), 64'(32'hA0));
        checkOutput("fill d4 in_ready", 64'(g_inst[1].bus.in_ready), 64'(0));
        applyStimulus(1'b1, 32'hA4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA4, 1'b0, 1'b0, 1'b0);
        checkOutput("stall d4 data", 64'(g_inst[1].bus.out_data), 64'(32'hA0));

        // Full with out_ready=1: simultaneous accept and emit.
        outReady = 1'b1;
        #1;
        checkOutput("full d4 in_ready", 64'(g_inst[1].bus.in_ready), 64'(1));
        applyStimulus(1'b1, 32'hA4, 1'b1, 1'b0, 1'b0);
        checkOutput("full d4 occupancy", 64'(g_inst[1].bus.occupancy), 64'(4));
        checkOutput("release d4 A1", 64'(g_inst[1].bus.out_data), 64'(32'hA1));
        applyStimulus(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0);
        checkOutput("release d4 A2", 64'(g_inst[1].bus.out_data), 64'(32'hA2));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("release d4 A3", 64'(g_inst[1].bus.out_data), 64'(32'hA3));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("release d4 A4", 64'(g_inst[1].bus.out_data), 64'(32'hA4));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("release d4 A5", 64'(g_inst[1].bus.out_data), 64'(32'hA5));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("release d4 empty", 64'(g_inst[1].bus.occupancy), 64'(0));

        // Bubbles with random backpressure.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(i % 2 == 0, W'(32'h1000 + i), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("bubble d3 drained", 64'(g_inst[0].bus.occupancy), 64'(0));
        checkOutput("bubble d4 drained", 64'(g_inst[1].bus.occupancy), 64'(0));

        // Reset in the middle of a stream discards in-flight words.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, W'(32'h77 + i), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h88, 1'b1, 1'b1, 1'b0);
        rst = 1'b0; inValid = 1'b0; outReady = 1'b0;
        #1;
        checkOutput("midreset out_valid", 64'(g_inst[0].bus.out_valid), 64'(0));
        checkOutput("midreset out_data", 64'(g_inst[0].bus.out_data), 64'(0));
        checkOutput("midreset occupancy", 64'(g_inst[0].bus.occupancy), 64'(0));
        checkOutput("midreset in_ready", 64'(g_inst[0].bus.in_ready), 64'(1));

`ifdef PIPE_FLUSH_EN
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("preflush d3 data", 64'(g_inst[0].bus.out_data), 64'(1));
        inValid = 1'b1; inData = 32'h9; flushDrv = 1'b1;
        #1;
        checkOutput("flush d3 in_ready", 64'(g_inst[0].bus.in_ready), 64'(0));
        applyStimulus(1'b1, 32'h9, 1'b0, 1'b0, 1'b1);
        checkOutput("flush d3 out_valid", 64'(g_inst[0].bus.out_valid), 64'(0));
        checkOutput("flush d3 occupancy", 64'(g_inst[0].bus.occupancy), 64'(0));
        checkOutput("flush d3 data kept", 64'(g_inst[0].bus.out_data), 64'(1));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("postflush d3 out_valid", 64'(g_inst[0].bus.out_valid), 64'(0));
`endif

        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
